// File: rtl/fp_pkg.sv
// fp_pkg: shared bf16 constants and accumulator state encoding
package fp_pkg;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    localparam logic [15:0] BF16_ONE = 16'h3F80;
    localparam int BIAS = 127;
endpackage

// File: rtl/bf16_accum_add.sv
// add: combinational bf16 adder, hidden bit always 1, truncating
module add (
    input  logic [15:0] a_reg,
    input  logic [15:0] b_reg,
    output logic [15:0] out_add
);
    logic       w_swap;
    logic [15:0] w_big;
    logic [15:0] w_sml;
    logic [7:0] w_d;
    logic [7:0] w_ma;
    logic [7:0] w_mb;
    logic [8:0] w_sum;
    logic [3:0] w_msb;
    logic [7:0] w_exp;
    logic [6:0] w_frac;
    // align the smaller magnitude, add or subtract, renormalise on the leading one
    always_comb begin
        w_swap = b_reg[14:0] > a_reg[14:0];
        w_big  = w_swap ? b_reg : a_reg;
        w_sml  = w_swap ? a_reg : b_reg;
        w_d    = w_big[14:7] - w_sml[14:7];
        w_ma   = {1'b1, w_big[6:0]};
        w_mb   = (w_d > 8'd7) ? 8'd0 : ({1'b1, w_sml[6:0]} >> w_d);
        w_sum  = (w_big[15] == w_sml[15]) ? {1'b0, w_ma} + {1'b0, w_mb} : {1'b0, w_ma} - {1'b0, w_mb};
        w_msb  = 4'd0;
        for (int i = 0; i < 9; i++)
            if (w_sum[i]) w_msb = 4'(i);
        w_frac  = 7'(({w_sum, 1'b0} << (4'd8 - w_msb)) >> 2);
        w_exp   = w_big[14:7] + {4'd0, w_msb} - 8'd7;
        out_add = (w_sum == 9'd0) ? 16'h0000 : {w_big[15], w_exp, w_frac};
    end
endmodule

// File: rtl/bf16_accum.sv
// bf16_accum: streams bf16 operands through one adder and returns the framed total
module bf16_accum
    import fp_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    input  logic             out_ready
);
    state_t           state;
    logic [15:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      w_sum;

    add u_add (.a_reg(r_acc), .b_reg(in_data), .out_add(w_sum));

    // first term loads directly, later terms go through the adder; DONE holds until drained
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (state == DONE) begin
            if (out_ready) state <= IDLE;
        end else if (in_valid) begin
            r_acc <= (state == IDLE) ? in_data : w_sum;
            r_cnt <= (state == IDLE) ? CNT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);
            state <= in_last ? DONE : ACC;
        end

    assign in_ready  = state != DONE;
    assign out_valid = state == DONE;
    assign out_data  = r_acc;
    assign out_count = r_cnt;
endmodule

// File: tb/tb_bf16_accum.sv
// tb_bf16_accum: directed and randomized checks of bf16_accum against a real-valued sum model
module tb_bf16_accum;
    import fp_pkg::*;
    localparam int CNT_W = 3;
    logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
    logic [15:0] in_data = '0;
    logic in_ready, out_valid;
    logic [15:0] out_data;
    logic [CNT_W-1:0] out_count;
    int n_chk = 0, n_pass = 0;

    bf16_accum #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_count(out_count), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "timeout");
    end

    function automatic real bf2r(input logic [15:0] x);
        real r = 1.0 + real'(x[6:0]) / 128.0;
        int e = int'(x[14:7]) - BIAS;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return x[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2bf(input real v);
        real r = v;
        int e = 0;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0) begin r = r * 2.0; e--; end
        return {1'b0, 8'(e + BIAS), 7'($rtoi((r - 1.0) * 128.0))};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        in_valid = 1; in_data = d; in_last = l;
        chk("in_ready_accept", 32'(in_ready), 1);
        tick();
        in_valid = 0; in_last = 0;
    endtask

    task automatic expect_done(input logic [15:0] d, input int c, input int hold);
        out_ready = 0; in_valid = 1; in_data = 16'h4000; in_last = 1;
        chk("out_valid", 32'(out_valid), 1);
        chk("out_data", 32'(out_data), 32'(d));
        chk("out_count", 32'(out_count), 32'(c));
        repeat (hold) begin
            tick();
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(out_data), 32'(d));
            chk("hold_count", 32'(out_count), 32'(c));
            chk("hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1; in_valid = 0; in_last = 0;
        tick();
        out_ready = 0;
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_ready", 32'(in_ready), 1);
    endtask

    task automatic run_sum(input logic [15:0] t[$], input int hold, input bit gaps);
        real s = 0.0;
        logic [15:0] e = t[0];
        int c = (t.size() > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : t.size();
        for (int i = 1; i < t.size(); i++) e = r2bf(bf2r(e) + bf2r(t[i]));
        for (int i = 0; i < t.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_last = 1'($urandom);
                tick();
                in_last = 0;
                chk("gap_no_valid", 32'(out_valid), 0);
            end
            send(t[i], i == t.size() - 1);
            if (i != t.size() - 1) chk("mid_no_valid", 32'(out_valid), 0);
        end
        s = bf2r(e);
        if (s < 0.0) $display("note: negative model sum");
        expect_done(e, c, hold);
    endtask

    initial begin
        logic [15:0] q[$];
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_count", 32'(out_count), 0);
        rst = 0;
        tick();
        run_sum('{BF16_ONE, 16'h4000}, 0, 0);
        chk("t1_value", 32'(out_data), 32'h4040);
        run_sum('{16'h3F80, 16'h4000, 16'h3F80}, 0, 0);
        run_sum('{16'h3F00}, 1, 0);
        run_sum('{16'h3F00, 16'h3F00}, 3, 0);
        chk("t3_value", 32'(out_data), 32'h3F80);
        q = {};
        repeat ((1 << CNT_W) + 2) q.push_back(16'h3F80);
        run_sum(q, 0, 0);
        chk("t4_value", 32'(out_data), 32'h4120);
        send(16'h3F80, 0);
        send(16'h4000, 0);
        #2 rst = 1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_count", 32'(out_count), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_ready", 32'(in_ready), 1);
        tick();
        rst = 0;
        run_sum('{16'h4000}, 0, 0);
        out_ready = 1; in_valid = 1;
        q = '{16'h3F80, 16'h4000, 16'h4040, 16'h3F80};
        for (int i = 0; i < 4; i++) begin
            in_data = q[i]; in_last = i[0];
            chk("b2b_ready", 32'(in_ready), 1);
            tick();
            if (i[0]) begin
                in_data = 16'h4100; in_last = 0;
                chk("b2b_busy", 32'(in_ready), 0);
                chk("b2b_valid", 32'(out_valid), 1);
                chk("b2b_data", 32'(out_data), i == 1 ? 32'h4040 : 32'h4080);
                chk("b2b_count", 32'(out_count), 2);
                tick();
            end
        end
        in_valid = 0; out_ready = 0; in_last = 0;
        for (int k = 0; k < 25; k++) begin
            q = {};
            repeat ($urandom_range(1, 9)) q.push_back({1'b0, 8'($urandom_range(124, 130)), 7'($urandom)});
            run_sum(q, $urandom_range(0, 2), 1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
